// File: rtl/execute_hazard_ctrl.sv
// execute_hazard_ctrl: operand forwarding, load-use stall and branch/jump redirect control for the execute stage.
// Optional PERF_COUNTERS_EN macro adds saturating branch/mispredict/stall counters.
module execute_hazard_ctrl #(
   parameter int FWD_STAGES  = 2,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             inst_execute,
   input  logic                    valid_execute,
   input  logic [32*FWD_STAGES-1:0] inst_older,
   input  logic [FWD_STAGES-1:0]   valid_older,
   input  logic                    br_eq,
   input  logic                    br_lt,
   input  logic                    br_pred_taken,
   input  logic                    bp_en,
   output logic [1:0]              fwd_sel_rs1,
   output logic [1:0]              fwd_sel_rs2,
   output logic                    stall,
   output logic [FLUSH_DEPTH-1:0]  flush,
   output logic [1:0]              pc_sel,
   output logic                    br_taken,
   output logic                    mispredict,
   output logic [31:0]             br_count,
   output logic [31:0]             mispred_count,
   output logic [31:0]             stall_count
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

   state_t state, next_state;
   logic [1:0] cnt, cnt_next;
   logic [6:0] op;
   logic [2:0] f3;
   logic [4:0] rs1, rs2;
   logic use_rs1, use_rs2, is_br, is_jump, cond, lu, live, take_pc, rec_pc, br_res;
   logic [1:0] sel1, sel2;
   logic [FWD_STAGES-1:0] prod, ld;
   logic [4:0] rd [FWD_STAGES];
   logic unused_bits;

   assign op      = inst_execute[6:0];
   assign f3      = inst_execute[14:12];
   assign rs1     = inst_execute[19:15];
   assign rs2     = inst_execute[24:20];
   assign use_rs1 = (op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR}) || (op == OP_SYS && !f3[2]);
   assign use_rs2 = op inside {OP_R, OP_STORE, OP_BR};
   assign is_br   = op == OP_BR;
   assign is_jump = op == OP_JAL || op == OP_JALR;
   assign live    = rst_n && valid_execute;
   assign unused_bits = ^{inst_execute[31:25], inst_execute[11:7], inst_older};

   for (genvar g = 0; g < FWD_STAGES; g++) begin : g_st
      assign rd[g]   = inst_older[32*g+7 +: 5];
      assign ld[g]   = inst_older[32*g +: 7] == OP_LOAD;
      assign prod[g] = valid_older[g] && inst_older[32*g +: 7] != OP_STORE
                       && inst_older[32*g +: 7] != OP_BR && rd[g] != 5'd0;
   end

   // Scan oldest to youngest so the youngest matching producer wins; a stage-0 load blocks forwarding.
   always_comb begin
      sel1 = 2'd0;
      sel2 = 2'd0;
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (use_rs1 && prod[k] && rd[k] == rs1) sel1 = (k == 0 && ld[0]) ? 2'd0 : 2'(k + 1);
         if (use_rs2 && prod[k] && rd[k] == rs2) sel2 = (k == 0 && ld[0]) ? 2'd0 : 2'(k + 1);
      end
   end

   assign lu = prod[0] && ld[0] && ((use_rs1 && rd[0] == rs1) || (use_rs2 && rd[0] == rs2));

   assign cond = f3[2] ? (f3[0] ? (br_eq || !br_lt) : (!br_eq && br_lt))
                       : (f3[1] ? 1'b0 : (f3[0] ? !br_eq : br_eq));
   assign take_pc = is_jump || (is_br && cond && !(bp_en && br_pred_taken));
   assign rec_pc  = is_br && bp_en && br_pred_taken && !cond;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= 2'd0;
      end else begin
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      next_state  = state;
      cnt_next    = cnt;
      stall       = 1'b0;
      flush       = '0;
      pc_sel      = 2'd0;
      br_taken    = 1'b0;
      mispredict  = 1'b0;
      fwd_sel_rs1 = 2'd0;
      fwd_sel_rs2 = 2'd0;
      br_res      = 1'b0;
      case (state)
         RUN: if (live) begin
            fwd_sel_rs1 = sel1;
            fwd_sel_rs2 = sel2;
            if (lu) begin
               stall      = 1'b1;
               cnt_next   = 2'(LOAD_LAT - 1);
               next_state = (LOAD_LAT > 1) ? LSTALL : RUN;
            end else begin
               br_res     = is_br;
               br_taken   = is_br && cond;
               mispredict = is_br && bp_en && (cond != br_pred_taken);
               pc_sel     = take_pc ? 2'd1 : rec_pc ? 2'd2 : 2'd0;
               if (take_pc || rec_pc) begin
                  flush      = '1;
                  next_state = FLUSH;
               end
            end
         end
         LSTALL: begin
            stall    = rst_n;
            cnt_next = cnt - 2'd1;
            if (live) begin
               fwd_sel_rs1 = sel1;
               fwd_sel_rs2 = sel2;
            end
            if (cnt <= 2'd1) next_state = RUN;
         end
         default: next_state = RUN;
      endcase
   end

`ifdef PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count      <= 32'd0;
         mispred_count <= 32'd0;
         stall_count   <= 32'd0;
      end else begin
         if (br_res && br_count != '1) br_count <= br_count + 32'd1;
         if (mispredict && mispred_count != '1) mispred_count <= mispred_count + 32'd1;
         if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
      end
   end
`else
   logic unused_perf;
   assign unused_perf   = br_res;
   assign br_count      = 32'd0;
   assign mispred_count = 32'd0;
   assign stall_count   = 32'd0;
`endif
endmodule

// File: tb/tb_execute_hazard_ctrl.sv
// tb_execute_hazard_ctrl: directed vectors with a queued scoreboard checked by a separate negedge monitor.
module tb_execute_hazard_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] inst_execute = '0;
   logic valid_execute = 1'b0;
   logic [63:0] inst_older = '0;
   logic [1:0] valid_older = '0;
   logic br_eq = 1'b0, br_lt = 1'b0, br_pred_taken = 1'b0, bp_en = 1'b0;
   logic [1:0] fwd_sel_rs1, fwd_sel_rs2, pc_sel;
   logic stall, br_taken, mispredict;
   logic [1:0] flush;
   logic [31:0] br_count, mispred_count, stall_count;

   always #5 clk = ~clk;

   execute_hazard_ctrl #(.FWD_STAGES(2), .LOAD_LAT(2), .FLUSH_DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n), .inst_execute(inst_execute), .valid_execute(valid_execute),
      .inst_older(inst_older), .valid_older(valid_older), .br_eq(br_eq), .br_lt(br_lt),
      .br_pred_taken(br_pred_taken), .bp_en(bp_en), .fwd_sel_rs1(fwd_sel_rs1),
      .fwd_sel_rs2(fwd_sel_rs2), .stall(stall), .flush(flush), .pc_sel(pc_sel),
      .br_taken(br_taken), .mispredict(mispredict), .br_count(br_count),
      .mispred_count(mispred_count), .stall_count(stall_count)
   );

`ifdef PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      logic [10:0] ctrl;
      logic [95:0] cnt;
      string       name;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] r(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
      return {7'd0, b, a, 3'd0, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] imm);
      return {7'd0, imm, a, 3'd0, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] a);
      return {12'd0, a, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] sw(input logic [4:0] b, input logic [4:0] a, input logic [4:0] imm);
      return {7'd0, b, a, 3'b010, imm, 7'b0100011};
   endfunction
   function automatic logic [31:0] br(input logic [2:0] f, input logic [4:0] a, input logic [4:0] b);
      return {7'd0, b, a, f, 5'd0, 7'b1100011};
   endfunction
   function automatic logic [31:0] jal(input logic [4:0] rd);
      return {20'd0, rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] csr(input logic [2:0] f, input logic [4:0] a);
      return {12'd0, a, f, 5'd1, 7'b1110011};
   endfunction
   function automatic logic [31:0] pc(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic cyc(input logic rr, input logic [31:0] ie, input logic ve,
                      input logic [31:0] o0, input logic [31:0] o1, input logic [1:0] vo,
                      input logic eq, input logic lt, input logic pred, input logic bpe,
                      input logic s, input logic [1:0] fl, input logic [1:0] pcs,
                      input logic [1:0] f1, input logic [1:0] f2, input logic bt, input logic mp,
                      input int bc, input int mc, input int sc, input string nm);
      @(posedge clk);
      #1;
      rst_n = rr;
      inst_execute = ie;
      valid_execute = ve;
      inst_older = {o1, o0};
      valid_older = vo;
      br_eq = eq;
      br_lt = lt;
      br_pred_taken = pred;
      bp_en = bpe;
      q.push_back('{ctrl: {s, fl, pcs, f1, f2, bt, mp}, cnt: {pc(bc), pc(mc), pc(sc)}, name: nm});
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         checks += 2;
         if ({stall, flush, pc_sel, fwd_sel_rs1, fwd_sel_rs2, br_taken, mispredict} !== e.ctrl) begin
            errors++;
            $display("FAIL %s ctrl {stall,flush,pc_sel,fwd1,fwd2,br_taken,mispred}: got %b want %b", e.name,
                     {stall, flush, pc_sel, fwd_sel_rs1, fwd_sel_rs2, br_taken, mispredict}, e.ctrl);
         end
         if ({br_count, mispred_count, stall_count} !== e.cnt) begin
            errors++;
            $display("FAIL %s counters {br,mispred,stall}: got %h want %h", e.name,
                     {br_count, mispred_count, stall_count}, e.cnt);
         end
      end
   end

   initial begin
      cyc(0, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 0,2'b00,0,0,0,0,0, 0,0,0, "reset");
      cyc(1, r(7,5,6), 1, r(5,1,2), r(6,1,2), 2'b11, 0,0,0,0, 0,2'b00,0,1,2,0,0, 0,0,0, "fwd_both");
      cyc(1, r(7,5,6), 1, r(5,1,2), r(6,1,2), 2'b01, 0,0,0,0, 0,2'b00,0,1,0,0,0, 0,0,0, "fwd_s1_invalid");
      cyc(1, r(7,6,6), 1, r(6,1,2), r(6,1,2), 2'b11, 0,0,0,0, 0,2'b00,0,1,1,0,0, 0,0,0, "fwd_lowest");
      cyc(1, r(7,0,0), 1, addi(0,1,0), 0, 2'b01, 0,0,0,0, 0,2'b00,0,0,0,0,0, 0,0,0, "rd_x0");
      cyc(1, r(7,5,5), 1, sw(5,1,5), r(5,1,2), 2'b01, 0,0,0,0, 0,2'b00,0,0,0,0,0, 0,0,0, "store_s0");
      cyc(1, r(7,5,6), 0, r(5,1,2), r(6,1,2), 2'b11, 0,0,0,0, 0,2'b00,0,0,0,0,0, 0,0,0, "bubble");
      cyc(1, addi(7,5,6), 1, r(5,1,2), r(6,1,2), 2'b11, 0,0,0,0, 0,2'b00,0,1,0,0,0, 0,0,0, "unused_rs2");
      cyc(1, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 0,0,0, "lu_enter");
      cyc(1, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 0,0,1, "lu_hold");
      cyc(1, r(1,5,0), 1, 0, lw(5,0), 2'b10, 0,0,0,0, 0,2'b00,0,2,0,0,0, 0,0,2, "lu_exit");
      cyc(1, br(3'b000,1,2), 1, 0, 0, 2'b00, 0,0,1,1, 0,2'b11,2,0,0,0,1, 0,0,2, "mispred_nt");
      cyc(1, br(3'b000,1,2), 1, 0, 0, 2'b00, 0,0,1,1, 0,2'b00,0,0,0,0,0, 1,1,2, "flush_state");
      cyc(1, 0, 0, 0, 0, 2'b00, 0,0,0,0, 0,2'b00,0,0,0,0,0, 1,1,2, "idle");
      cyc(1, br(3'b001,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 1,1,2, "br_lu");
      cyc(1, br(3'b001,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 1,1,3, "br_lstall");
      cyc(1, br(3'b001,5,0), 1, 0, lw(5,0), 2'b10, 0,0,0,0, 0,2'b11,1,2,0,1,0, 1,1,4, "br_resolve");
      cyc(1, br(3'b001,5,0), 1, 0, lw(5,0), 2'b10, 0,0,0,0, 0,2'b00,0,0,0,0,0, 2,1,4, "flush_after_br");
      cyc(1, jal(1), 1, 0, 0, 2'b00, 0,0,0,0, 0,2'b11,1,0,0,0,0, 2,1,4, "jal");
      cyc(1, jal(1), 1, 0, 0, 2'b00, 0,0,0,0, 0,2'b00,0,0,0,0,0, 2,1,4, "flush_after_jal");
      cyc(1, br(3'b100,1,2), 1, 0, 0, 2'b00, 0,1,0,1, 0,2'b11,1,0,0,1,1, 2,1,4, "blt_mispred");
      cyc(1, br(3'b100,1,2), 1, 0, 0, 2'b00, 0,1,0,1, 0,2'b00,0,0,0,0,0, 3,2,4, "flush_after_blt");
      cyc(1, br(3'b101,1,2), 1, 0, 0, 2'b00, 0,1,0,1, 0,2'b00,0,0,0,0,0, 3,2,4, "bge_nt");
      cyc(1, br(3'b101,1,2), 1, 0, 0, 2'b00, 1,1,1,1, 0,2'b00,0,0,0,1,0, 4,2,4, "bge_pred_ok");
      cyc(1, br(3'b000,1,2), 1, 0, 0, 2'b00, 0,0,1,0, 0,2'b00,0,0,0,0,0, 5,2,4, "beq_nobp");
      cyc(1, 0, 0, 0, 0, 2'b00, 0,0,0,0, 0,2'b00,0,0,0,0,0, 6,2,4, "idle2");
      cyc(1, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 6,2,4, "lu2");
      cyc(0, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 0,2'b00,0,0,0,0,0, 0,0,0, "reset_lstall");
      cyc(1, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 0,0,0, "post_reset");
      cyc(1, r(1,5,0), 1, lw(5,0), 0, 2'b01, 0,0,0,0, 1,2'b00,0,0,0,0,0, 0,0,1, "lstall2");
      cyc(1, csr(3'b001,5), 1, r(5,1,2), 0, 2'b01, 0,0,0,0, 0,2'b00,0,1,0,0,0, 0,0,2, "csrrw");
      cyc(1, csr(3'b101,5), 1, r(5,1,2), 0, 2'b01, 0,0,0,0, 0,2'b00,0,0,0,0,0, 0,0,2, "csrrwi");
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
